// File: rtl/matrix_loader.sv
// rtl/matrix_loader.sv - streams a GF(M) matrix into the systemizer memory, kicks it and latches the result
module matrix_loader #(
  parameter int L     = 8,
  parameter int K     = 16,
  parameter int M     = 3,
  parameter int BLOCK = 4,
  localparam int EW    = $clog2(M),
  localparam int WORDS = L * K / BLOCK,
  localparam int AW    = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  elem_valid,
  input  logic [EW-1:0]         elem_data,
  output logic                  elem_ready,
  output logic                  mem_wr_en,
  output logic [AW-1:0]         mem_wr_addr,
  output logic [BLOCK*EW-1:0]   mem_wr_data,
  output logic                  sys_start,
  input  logic                  sys_done,
  input  logic                  sys_fail,
  input  logic                  sys_success,
  output logic                  busy,
  output logic                  load_err,
  output logic                  result_valid,
  output logic                  result_fail,
  output logic                  result_success
);

  localparam int          TOTAL = L * K;
  localparam int          CW    = $clog2(TOTAL);
  localparam logic [EW:0] M_W   = (EW + 1)'(M);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_FLUSH,
    ST_KICK,
    ST_WAIT,
    ST_ERR
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CW-1:0]        elem_cnt;
  logic [BLOCK*EW-1:0]  pack;
  logic [BLOCK*EW-1:0]  pack_nxt;
  logic                 accept;
  logic                 bad_elem;
  logic                 last_elem;
  logic                 word_end;
  logic                 start_load;

  // Elements enter at the top and shift down, so after BLOCK beats the first one sits in the LSBs.
  assign pack_nxt   = {elem_data, pack[BLOCK*EW-1:EW]};
  assign accept     = elem_valid && (state == ST_FILL);
  assign bad_elem   = {1'b0, elem_data} >= M_W;
  assign last_elem  = elem_cnt == CW'(TOTAL - 1);
  assign word_end   = (elem_cnt % CW'(BLOCK)) == CW'(BLOCK - 1);
  assign start_load = load && ((state == ST_IDLE) || (state == ST_ERR));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nxt  = state;
    elem_ready = 1'b0;
    sys_start  = 1'b0;
    busy       = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (load) state_nxt = ST_FILL;
      end
      ST_FILL: begin
        elem_ready = 1'b1;
        if (accept) begin
          if (bad_elem)       state_nxt = ST_ERR;
          else if (last_elem) state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: state_nxt = ST_KICK;
      ST_KICK: begin
        sys_start = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (sys_done) state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        busy = 1'b0;
        if (load) state_nxt = ST_FILL;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Packing, word writes, error flag and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem_cnt       <= '0;
      pack           <= '0;
      mem_wr_en      <= 1'b0;
      mem_wr_addr    <= '0;
      mem_wr_data    <= '0;
      load_err       <= 1'b0;
      result_valid   <= 1'b0;
      result_fail    <= 1'b0;
      result_success <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;
      if (start_load) begin
        elem_cnt       <= '0;
        pack           <= '0;
        mem_wr_addr    <= '0;
        load_err       <= 1'b0;
        result_valid   <= 1'b0;
        result_fail    <= 1'b0;
        result_success <= 1'b0;
      end else if (accept) begin
        if (bad_elem) begin
          // The partial word is simply never written; ERR blocks further beats.
          load_err <= 1'b1;
        end else begin
          pack     <= pack_nxt;
          elem_cnt <= elem_cnt + 1'b1;
          if (word_end) begin
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= AW'(elem_cnt / CW'(BLOCK));
            mem_wr_data <= pack_nxt;
          end
        end
      end
      if ((state == ST_WAIT) && sys_done) begin
        result_valid   <= 1'b1;
        result_fail    <= sys_fail;
        result_success <= sys_success;
      end
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// tb/tb_matrix_loader.sv - scoreboard bench for matrix_loader
module tb_matrix_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic       elem_valid = 1'b0;
  logic [1:0] elem_data = 2'd0;
  logic       elem_ready;
  logic       mem_wr_en;
  logic [4:0] mem_wr_addr;
  logic [7:0] mem_wr_data;
  logic       sys_start;
  logic       sys_done = 1'b0;
  logic       sys_fail = 1'b0;
  logic       sys_success = 1'b0;
  logic       busy;
  logic       load_err;
  logic       result_valid;
  logic       result_fail;
  logic       result_success;

  matrix_loader dut (
    .clk(clk), .rst(rst), .load(load),
    .elem_valid(elem_valid), .elem_data(elem_data), .elem_ready(elem_ready),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .sys_start(sys_start), .sys_done(sys_done), .sys_fail(sys_fail), .sys_success(sys_success),
    .busy(busy), .load_err(load_err), .result_valid(result_valid),
    .result_fail(result_fail), .result_success(result_success)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [12:0] exp_q[$];
  logic [12:0] exp_e;
  logic [1:0]  mat[128];
  int          wr_cnt = 0;
  int          load_wr = 0;
  int          start_cnt = 0;
  logic        prev_wr = 1'b0;
  logic [4:0]  prev_addr = 5'd0;
  logic        prev_start = 1'b0;
  logic [7:0]  first_data = 8'd0;
  logic        in_fill = 1'b0;
  logic        busy_drop = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write is popped against the scoreboard; start pulses are checked against the last write.
  always @(negedge clk) begin
    if (rst) begin
      prev_wr    = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (mem_wr_en) begin
        wr_cnt++;
        if (load_wr == 0) first_data = mem_wr_data;
        load_wr++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(mem_wr_addr), 32'hFFFF);
        end else begin
          exp_e = exp_q.pop_front();
          check("wr_addr", 32'(mem_wr_addr), 32'(exp_e[12:8]));
          check("wr_data", 32'(mem_wr_data), 32'(exp_e[7:0]));
        end
      end
      if (sys_start) begin
        start_cnt++;
        check("start_after_last_write", 32'({prev_wr, prev_addr}), 32'h3F);
        check("start_width", 32'(prev_start), 32'h0);
      end
      if (in_fill && !busy) busy_drop = 1'b1;
      prev_wr    = mem_wr_en;
      prev_addr  = mem_wr_addr;
      prev_start = sys_start;
    end
  end

  task automatic do_load();
    @(negedge clk);
    load    = 1'b1;
    load_wr = 0;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Drives n beats from mat; gap inserts an idle cycle before each beat. Stops after an illegal element.
  task automatic feed(input int n, input bit gap);
    int acc;
    int slot;
    int guard;
    logic [7:0] word;
    acc  = 0;
    word = 8'd0;
    while (acc < n) begin
      if (gap) begin
        @(negedge clk);
        elem_valid = 1'b0;
      end
      @(negedge clk);
      elem_valid = 1'b1;
      elem_data  = mat[acc];
      guard = 0;
      while (!elem_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (!elem_ready) begin
        check("ready_timeout", 32'(elem_ready), 32'h1);
        break;
      end
      @(posedge clk);
      if (mat[acc] == 2'd3) break;
      slot = acc % 4;
      word = word | (8'(mat[acc]) << (2 * slot));
      if (slot == 3) begin
        exp_q.push_back({5'(acc / 4), word});
        word = 8'd0;
      end
      acc++;
    end
    @(negedge clk);
    elem_valid = 1'b0;
  endtask

  task automatic finish_load(input int delay, input logic f, input logic s, input int exp_starts);
    int g;
    g = 0;
    while (start_cnt < exp_starts && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("start_seen", 32'(start_cnt), 32'(exp_starts));
    repeat (delay) @(negedge clk);
    sys_done    = 1'b1;
    sys_fail    = f;
    sys_success = s;
    @(negedge clk);
    sys_done    = 1'b0;
    sys_fail    = 1'b0;
    sys_success = 1'b0;
    #1;
    check("result_valid", 32'(result_valid), 32'h1);
    check("result_fail", 32'(result_fail), 32'(f));
    check("result_success", 32'(result_success), 32'(s));
    check("busy_after_done", 32'(busy), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_flags", 32'({elem_ready, mem_wr_en, sys_start, busy, load_err,
                              result_valid, result_fail, result_success}), 32'h0);
    check("reset_wr_bus", 32'({mem_wr_addr, mem_wr_data}), 32'h0);
    rst = 1'b0;
    // sys_done in IDLE must be ignored
    @(negedge clk);
    sys_done = 1'b1;
    sys_success = 1'b1;
    @(negedge clk);
    sys_done = 1'b0;
    sys_success = 1'b0;
    #1;
    check("done_ignored_idle", 32'({result_valid, result_success, busy}), 32'h0);

    // Full load of all ones: 32 words of 8'h55, success result
    for (int i = 0; i < 128; i++) mat[i] = 2'd1;
    do_load();
    feed(128, 1'b0);
    finish_load(10, 1'b0, 1'b1, 1);
    check("load1_writes", 32'(load_wr), 32'd32);
    check("load1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Toggling valid, first word 0,1,2,0, load while busy ignored, fail result
    for (int i = 0; i < 128; i++) mat[i] = 2'((i * 5) % 3);
    mat[0] = 2'd0; mat[1] = 2'd1; mat[2] = 2'd2; mat[3] = 2'd0;
    do_load();
    busy_drop = 1'b0;
    in_fill = 1'b1;
    feed(128, 1'b1);
    in_fill = 1'b0;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    finish_load(3, 1'b1, 1'b0, 2);
    check("first_word", 32'(first_data), 32'h24);
    check("load2_writes", 32'(load_wr), 32'd32);
    check("busy_held", 32'(busy_drop), 32'h0);

    // Illegal element at beat 5
    for (int i = 0; i < 128; i++) mat[i] = 2'd1;
    mat[5] = 2'd3;
    do_load();
    feed(128, 1'b0);
    check("err_flags", 32'({load_err, busy, elem_ready}), 32'h4);
    repeat (10) @(negedge clk);
    check("err_writes", 32'(load_wr), 32'd1);
    check("err_no_start", 32'(start_cnt), 32'd2);
    do_load();
    #1;
    check("reload_clears_err", 32'({load_err, busy}), 32'h1);

    // Reset in the middle of a load
    mat[5] = 2'd1;
    feed(62, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_flags", 32'({elem_ready, mem_wr_en, sys_start, busy, load_err,
                            result_valid, result_fail, result_success}), 32'h0);
    check("rst_writes_before", 32'(load_wr), 32'd15);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 128; i++) mat[i] = 2'd2;
    do_load();
    feed(128, 1'b0);
    finish_load(2, 1'b0, 1'b1, 3);
    check("load4_writes", 32'(load_wr), 32'd32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
